countdown_timer: RTL and testbench

Two-digit BCD countdown timer that shows the player the game time remaining on HEX1/HEX0. It is loaded with a start time, counts down one second per CLOCK_FREQUENCY cycles, and flags TimeUp when it reaches 00. It is the down-counting counterpart of the elapsed-time counter. Its digit outputs feed the existing hex_decoder instances, and TimeUp feeds the game-control FSM.

---
 rtl/countdown_timer.sv | 176 +++++++++++++++++
 tb/tb_countdown_timer.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/countdown_timer.sv
// Two-digit BCD countdown timer with IDLE/RUN/PAUSE/DONE control and a
// CLOCK_FREQUENCY-cycle prescaler. Optional Warning output: COUNTDOWN_WARN_EN.
module countdown_timer #(
    parameter int CLOCK_FREQUENCY = 50000000,
    parameter int WARN_SECONDS    = 10
) (
    input  logic       ClockIn,
    input  logic       Resetn,
    input  logic       Load,
    input  logic [7:0] StartValue,
    input  logic       Start,
    input  logic       Pause,
    output logic [3:0] OnesCounterValue,
    output logic [3:0] TensCounterValue,
    output logic       Running,
    output logic       TickOut,
    output logic       TimeUp,
    output logic       Warning
);

    localparam int             PW        = $clog2(CLOCK_FREQUENCY);
    localparam logic [PW-1:0]  PRESC_MAX = PW'(CLOCK_FREQUENCY - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t        state_r;
    state_t        state_nx_s;
    logic [PW-1:0] presc_r;
    logic [PW-1:0] presc_nx_s;
    logic [3:0]    tens_r;
    logic [3:0]    ones_r;
    logic [3:0]    tens_nx_s;
    logic [3:0]    ones_nx_s;
    logic          tick_nx_s;

    function automatic logic [3:0] clamp_digit(input logic [3:0] d);
        if (d > 4'd9) begin
            clamp_digit = 4'd9;
        end else begin
            clamp_digit = d;
        end
    endfunction

    // BCD decrement that saturates at 00 rather than wrapping.
    function automatic logic [7:0] bcd_dec(input logic [3:0] t, input logic [3:0] o);
        if (o != 4'd0) begin
            bcd_dec = {t, o - 4'd1};
        end else if (t != 4'd0) begin
            bcd_dec = {t - 4'd1, 4'd9};
        end else begin
            bcd_dec = 8'h00;
        end
    endfunction

    // Next-state, prescaler and digit computation.
    always_comb begin
        state_nx_s = state_r;
        presc_nx_s = presc_r;
        tens_nx_s  = tens_r;
        ones_nx_s  = ones_r;
        tick_nx_s  = 1'b0;
        if (Load) begin
            tens_nx_s  = clamp_digit(StartValue[7:4]);
            ones_nx_s  = clamp_digit(StartValue[3:0]);
            presc_nx_s = PRESC_MAX;
            state_nx_s = IDLE;
        end else begin
            case (state_r)
                IDLE: begin
                    if (Start) begin
                        state_nx_s = ({tens_r, ones_r} == 8'h00) ? DONE : RUN;
                    end else begin
                        state_nx_s = IDLE;
                    end
                end
                RUN: begin
                    // The pause edge still consumes its RUN cycle, so resume loses nothing.
                    if (Pause) begin
                        state_nx_s = PAUSE;
                    end else begin
                        state_nx_s = RUN;
                    end
                    if (presc_r == '0) begin
                        presc_nx_s             = PRESC_MAX;
                        tick_nx_s              = 1'b1;
                        {tens_nx_s, ones_nx_s} = bcd_dec(tens_r, ones_r);
                        if (bcd_dec(tens_r, ones_r) == 8'h00) begin
                            state_nx_s = DONE;
                        end else begin
                            state_nx_s = state_nx_s;
                        end
                    end else begin
                        presc_nx_s = presc_r - PW'(1);
                    end
                end
                PAUSE: begin
                    if (Start && !Pause) begin
                        state_nx_s = RUN;
                    end else begin
                        state_nx_s = PAUSE;
                    end
                end
                DONE: begin
                    state_nx_s = DONE;
                    tens_nx_s  = 4'd0;
                    ones_nx_s  = 4'd0;
                end
                default: begin
                    state_nx_s = IDLE;
                end
            endcase
        end
    end

    // State, prescaler and registered outputs.
    always_ff @(posedge ClockIn or negedge Resetn) begin
        if (!Resetn) begin
            state_r          <= IDLE;
            presc_r          <= PRESC_MAX;
            tens_r           <= 4'd0;
            ones_r           <= 4'd0;
            TensCounterValue <= 4'd0;
            OnesCounterValue <= 4'd0;
            Running          <= 1'b0;
            TickOut          <= 1'b0;
            TimeUp           <= 1'b0;
        end else begin
            state_r          <= state_nx_s;
            presc_r          <= presc_nx_s;
            tens_r           <= tens_nx_s;
            ones_r           <= ones_nx_s;
            TensCounterValue <= tens_nx_s;
            OnesCounterValue <= ones_nx_s;
            Running          <= (state_nx_s == RUN);
            TickOut          <= tick_nx_s;
            TimeUp           <= (state_nx_s == DONE);
        end
    end

`ifdef COUNTDOWN_WARN_EN
    localparam logic [7:0] WARN_VAL = 8'(WARN_SECONDS);

    logic [7:0] secs_nx_s;
    logic       warn_nx_s;
    logic       warning_r;

    // Decimal remaining time compared against the threshold.
    always_comb begin
        secs_nx_s = ({4'd0, tens_nx_s} * 8'd10) + {4'd0, ones_nx_s};
        if (((state_nx_s == RUN) || (state_nx_s == PAUSE)) && (secs_nx_s <= WARN_VAL)) begin
            warn_nx_s = 1'b1;
        end else begin
            warn_nx_s = 1'b0;
        end
    end

    // Warning register, updated alongside the digits.
    always_ff @(posedge ClockIn or negedge Resetn) begin
        if (!Resetn) begin
            warning_r <= 1'b0;
        end else begin
            warning_r <= warn_nx_s;
        end
    end

    assign Warning = warning_r;
`else
    assign Warning = 1'b0;
`endif

endmodule

// File: tb/tb_countdown_timer.sv
// Scoreboard bench for countdown_timer: a seconds/phase reference model
// queues expected outputs per edge; a monitor pops and compares on negedge.
module tb_countdown_timer;

    localparam int CF = 4;
    localparam int WS = 10;
    localparam int M_IDLE = 0, M_RUN = 1, M_PAUSE = 2, M_DONE = 3;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       load, start, pause;
    logic [7:0] sv;
    logic [3:0] ones, tens;
    logic       running, tick, time_up, warning;

    always #5 clk = ~clk;

    countdown_timer #(.CLOCK_FREQUENCY(CF), .WARN_SECONDS(WS)) dut (
        .ClockIn(clk), .Resetn(rst_n), .Load(load), .StartValue(sv),
        .Start(start), .Pause(pause), .OnesCounterValue(ones),
        .TensCounterValue(tens), .Running(running), .TickOut(tick),
        .TimeUp(time_up), .Warning(warning)
    );

    typedef struct {
        logic [3:0] t;
        logic [3:0] o;
        logic       run;
        logic       tk;
        logic       up;
        logic       wn;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;

    int tests = 0;
    int fails = 0;

    // Reference model: remaining seconds as an integer, RUN cycles spent in the current second.
    int m_secs  = 0;
    int m_phase = 0;
    int m_mode  = M_IDLE;
    bit m_tick  = 1'b0;

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic exp_t model_out();
        exp_t e;
        e.t   = 4'(m_secs / 10);
        e.o   = 4'(m_secs % 10);
        e.run = (m_mode == M_RUN);
        e.tk  = m_tick;
        e.up  = (m_mode == M_DONE);
`ifdef COUNTDOWN_WARN_EN
        e.wn  = ((m_mode == M_RUN) || (m_mode == M_PAUSE)) && (m_secs <= WS);
`else
        e.wn  = 1'b0;
`endif
        return e;
    endfunction

    task automatic model_reset();
        m_secs  = 0;
        m_phase = 0;
        m_mode  = M_IDLE;
        m_tick  = 1'b0;
    endtask

    task automatic model_step(input logic l, input logic [7:0] v, input logic s, input logic p);
        int t, o;
        m_tick = 1'b0;
        if (l) begin
            t = (v[7:4] > 4'd9) ? 9 : int'(v[7:4]);
            o = (v[3:0] > 4'd9) ? 9 : int'(v[3:0]);
            m_secs  = t * 10 + o;
            m_phase = 0;
            m_mode  = M_IDLE;
        end else begin
            case (m_mode)
                M_IDLE:  if (s) m_mode = (m_secs == 0) ? M_DONE : M_RUN;
                M_RUN: begin
                    m_phase++;
                    if (m_phase == CF) begin
                        m_phase = 0;
                        m_secs--;
                        m_tick  = 1'b1;
                    end
                    if (m_secs == 0) m_mode = M_DONE;
                    else if (p)      m_mode = M_PAUSE;
                end
                M_PAUSE: if (s && !p) m_mode = M_RUN;
                default: ;
            endcase
        end
    endtask

    task automatic cycle(input logic l, input logic [7:0] v, input logic s, input logic p);
        @(negedge clk);
        load = l; sv = v; start = s; pause = p;
        @(posedge clk);
        model_step(l, v, s, p);
        exp_q.push_back(model_out());
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 8'h00, 1'b0, 1'b0);
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_ones"}, 8'(ones), 8'h00);
        chk({tag, "_tens"}, 8'(tens), 8'h00);
        chk({tag, "_running"}, 8'(running), 8'h00);
        chk({tag, "_tick"}, 8'(tick), 8'h00);
        chk({tag, "_timeup"}, 8'(time_up), 8'h00);
        chk({tag, "_warning"}, 8'(warning), 8'h00);
    endtask

    // Asynchronous reset between edges; outputs must clear without a clock edge.
    task automatic do_reset();
        @(negedge clk);
        load = 1'b0; start = 1'b0; pause = 1'b0; sv = 8'h00;
        #2 rst_n = 1'b0;
        #1 check_zero("async_reset");
        model_reset();
        @(posedge clk);
        exp_q.push_back(model_out());
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Monitor: one expected snapshot per active edge.
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            mon_e = exp_q.pop_front();
            chk("ones",    8'(ones),    8'(mon_e.o));
            chk("tens",    8'(tens),    8'(mon_e.t));
            chk("running", 8'(running), 8'(mon_e.run));
            chk("tick",    8'(tick),    8'(mon_e.tk));
            chk("timeup",  8'(time_up), 8'(mon_e.up));
            chk("warning", 8'(warning), 8'(mon_e.wn));
        end
    end

    initial begin
        logic       l, s, p;
        logic [7:0] v;
        rst_n = 1'b0; load = 1'b0; start = 1'b0; pause = 1'b0; sv = 8'h00;
        #1 check_zero("reset_state");
        @(negedge clk);
        rst_n = 1'b1;

        // Load 12 and count down to 09.
        cycle(1'b1, 8'h12, 1'b0, 1'b0);
        cycle(1'b0, 8'h00, 1'b1, 1'b0);
        idle(13);
        // Load 01: final decrement lands in DONE; a further Start is ignored.
        cycle(1'b1, 8'h01, 1'b0, 1'b0);
        cycle(1'b0, 8'h00, 1'b1, 1'b0);
        idle(5);
        cycle(1'b0, 8'h00, 1'b1, 1'b0);
        idle(2);
        // Pause two cycles in, hold, resume.
        cycle(1'b1, 8'h05, 1'b0, 1'b0);
        cycle(1'b0, 8'h00, 1'b1, 1'b0);
        idle(1);
        cycle(1'b0, 8'h00, 1'b0, 1'b1);
        idle(10);
        cycle(1'b0, 8'h00, 1'b1, 1'b0);
        idle(6);
        // Start and Pause together while paused stays paused.
        cycle(1'b0, 8'h00, 1'b0, 1'b1);
        cycle(1'b0, 8'h00, 1'b1, 1'b1);
        idle(3);
        // Clamping and Start from 00.
        cycle(1'b1, 8'hAF, 1'b0, 1'b0);
        idle(1);
        cycle(1'b1, 8'h00, 1'b0, 1'b0);
        cycle(1'b0, 8'h00, 1'b1, 1'b0);
        idle(2);
        // Reset mid-run, then Load with Start keeps IDLE.
        cycle(1'b1, 8'h12, 1'b0, 1'b0);
        cycle(1'b0, 8'h00, 1'b1, 1'b0);
        idle(5);
        do_reset();
        cycle(1'b1, 8'h03, 1'b1, 1'b0);
        idle(3);
        cycle(1'b0, 8'h00, 1'b1, 1'b0);
        idle(14);

        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 999) == 0) begin
                do_reset();
            end
            l = ($urandom_range(0, 63) == 0);
            s = ($urandom_range(0, 7) == 0);
            p = ($urandom_range(0, 15) == 0);
            v = 8'($urandom);
            cycle(l, v, s, p);
        end

        @(negedge clk);
        @(negedge clk);
        chk("queue_drained", 8'(exp_q.size()), 8'h00);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
